// File: rtl/rat_intr_pkg.sv
// Shared definitions for the RAT interrupt controller: FSM states,
// source count limit and default I/O port addresses.
package rat_intr_pkg;

  localparam int MAX_SRC = 8;

  localparam logic [7:0] MASK_PORT_ID_DEF  = 8'h20;
  localparam logic [7:0] CLR_PORT_ID_DEF   = 8'h21;
  localparam logic [7:0] CAUSE_PORT_ID_DEF = 8'h22;
  localparam logic [7:0] PEND_PORT_ID_DEF  = 8'h23;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SVC
  } intr_state_e;

endpackage

// File: rtl/intr_controller_if.sv
// Interrupt lines, control-unit handshake and I/O port bus of the
// interrupt controller; the controller sits on the slave modport.
interface intr_controller_if #(
  parameter int NUM_SRC = 8
);

  logic [NUM_SRC-1:0] IRQ_IN;
  logic               I_SET;
  logic               I_CLR;
  logic               INTR_ACK;
  logic               IO_STRB;
  logic [7:0]         PORT_ID;
  logic [7:0]         OUT_PORT;
  logic               INTR;
  logic               I_FLAG;
  logic [2:0]         INTR_ID;
  logic [7:0]         IN_DATA;

  modport master (
    output IRQ_IN, I_SET, I_CLR, INTR_ACK, IO_STRB, PORT_ID, OUT_PORT,
    input  INTR, I_FLAG, INTR_ID, IN_DATA
  );

  modport slave (
    input  IRQ_IN, I_SET, I_CLR, INTR_ACK, IO_STRB, PORT_ID, OUT_PORT,
    output INTR, I_FLAG, INTR_ID, IN_DATA
  );

endinterface

// File: rtl/intr_controller_edge_sync.sv
// One interrupt line: two-flop synchroniser followed by a delay flop
// whose comparison yields a single-cycle rising-edge pulse.
module intr_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
    rise_o  = sync2_q & ~dly_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

endmodule

// File: rtl/intr_controller.sv
// Interrupt controller feeding the RAT control unit's INTR input: pending
// capture, software mask, global I flag, priority select and cause register.
module intr_controller
  import rat_intr_pkg::*;
#(
  parameter int         NUM_SRC       = 8,
  parameter logic [7:0] MASK_PORT_ID  = MASK_PORT_ID_DEF,
  parameter logic [7:0] CLR_PORT_ID   = CLR_PORT_ID_DEF,
  parameter logic [7:0] CAUSE_PORT_ID = CAUSE_PORT_ID_DEF,
  parameter logic [7:0] PEND_PORT_ID  = PEND_PORT_ID_DEF
) (
  input logic               CLK,
  input logic               RESET_N,
  intr_controller_if.slave  bus
);

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] active, win_onehot, clr_bits;
  logic               i_flag_q, i_flag_d;
  logic [2:0]         intr_id_q, intr_id_d;
  logic [2:0]         winner;
  logic               mask_wr, clr_wr, ack_take;
  intr_state_e        state_q, state_d;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    intr_edge_sync u_sync (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .async_in (bus.IRQ_IN[g]),
      .rise_o   (rise[g])
    );
  end

  // Lowest active index wins; a fresh edge outranks any clear of the same bit.
  always_comb begin
    mask_wr = bus.IO_STRB && (bus.PORT_ID == MASK_PORT_ID);
    clr_wr  = bus.IO_STRB && (bus.PORT_ID == CLR_PORT_ID);
    active  = pending_q & mask_q;

    winner     = '0;
    win_onehot = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        winner        = 3'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end

    ack_take  = (state_q == ST_REQ) && bus.INTR_ACK && (|active);
    clr_bits  = (clr_wr ? bus.OUT_PORT[NUM_SRC-1:0] : '0) |
                (ack_take ? win_onehot : '0);
    pending_d = (pending_q & ~clr_bits) | rise;
    mask_d    = mask_wr ? bus.OUT_PORT[NUM_SRC-1:0] : mask_q;
    intr_id_d = ack_take ? winner : intr_id_q;

    i_flag_d = i_flag_q;
    if (bus.I_CLR)      i_flag_d = 1'b0;
    else if (bus.I_SET) i_flag_d = 1'b1;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_flag_q && (|active)) state_d = ST_REQ;
      ST_REQ: begin
        if (ack_take)                        state_d = ST_SVC;
        else if (bus.I_CLR || !(|active))    state_d = ST_IDLE;
      end
      ST_SVC:  if (i_flag_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      pending_q <= '0;
      mask_q    <= '0;
      i_flag_q  <= 1'b0;
      intr_id_q <= '0;
      state_q   <= ST_IDLE;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      i_flag_q  <= i_flag_d;
      intr_id_q <= intr_id_d;
      state_q   <= state_d;
    end
  end

  // A CLI executing during the request cycle must drop INTR immediately.
  always_comb begin
    bus.INTR    = (state_q == ST_REQ) && !bus.I_CLR;
    bus.I_FLAG  = i_flag_q;
    bus.INTR_ID = intr_id_q;
    bus.IN_DATA = 8'h00;
    if (bus.PORT_ID == CAUSE_PORT_ID) begin
      bus.IN_DATA[2:0] = intr_id_q;
    end else if (bus.PORT_ID == PEND_PORT_ID) begin
      bus.IN_DATA[NUM_SRC-1:0] = pending_q;
    end
  end

endmodule

// File: tb/tb_intr_controller.sv
// Directed self-checking bench for intr_controller: capture latency, masking,
// priority, CLI suppression, ignored acks, edge-vs-clear race and reset.
module tb_intr_controller;

  logic CLK;
  logic RESET_N;
  int   checks;
  int   failures;

  intr_controller_if #(.NUM_SRC(8)) bus ();

  intr_controller #(.NUM_SRC(8)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] id, input logic [7:0] data);
    bus.IO_STRB  = 1'b1;
    bus.PORT_ID  = id;
    bus.OUT_PORT = data;
    tick(1);
    bus.IO_STRB  = 1'b0;
    bus.OUT_PORT = 8'h00;
    bus.PORT_ID  = 8'h23;
    #1;
  endtask

  task automatic pulseSet();
    bus.I_SET = 1'b1;
    tick(1);
    bus.I_SET = 1'b0;
  endtask

  task automatic ackCycle();
    bus.INTR_ACK = 1'b1;
    bus.I_CLR    = 1'b1;
    tick(1);
    bus.INTR_ACK = 1'b0;
    bus.I_CLR    = 1'b0;
    #1;
  endtask

  task automatic readCause(input string tag, input logic [7:0] exp);
    bus.PORT_ID = 8'h22;
    #1;
    checkOutput(tag, bus.IN_DATA, exp);
    bus.PORT_ID = 8'h23;
    #1;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    RESET_N      = 1'b0;
    bus.IRQ_IN   = 8'h00;
    bus.I_SET    = 1'b0;
    bus.I_CLR    = 1'b0;
    bus.INTR_ACK = 1'b0;
    bus.IO_STRB  = 1'b0;
    bus.PORT_ID  = 8'h23;
    bus.OUT_PORT = 8'h00;
    tick(2);
    RESET_N = 1'b1;
    #1;
    checkOutput("rst_intr", {7'b0, bus.INTR}, 8'h00);
    checkOutput("rst_iflag", {7'b0, bus.I_FLAG}, 8'h00);
    checkOutput("rst_id", {5'b0, bus.INTR_ID}, 8'h00);
    checkOutput("rst_pend", bus.IN_DATA, 8'h00);

    $display("[TB] single source capture and acknowledge");
    applyStimulus(8'h20, 8'h05);
    pulseSet();
    checkOutput("iset", {7'b0, bus.I_FLAG}, 8'h01);
    bus.IRQ_IN = 8'h04;
    tick(2);
    checkOutput("lat2_pend", bus.IN_DATA, 8'h00);
    tick(1);
    checkOutput("lat3_pend", bus.IN_DATA, 8'h04);
    checkOutput("lat3_intr", {7'b0, bus.INTR}, 8'h00);
    tick(1);
    checkOutput("req_intr", {7'b0, bus.INTR}, 8'h01);
    ackCycle();
    checkOutput("ack_id", {5'b0, bus.INTR_ID}, 8'h02);
    checkOutput("ack_pend", bus.IN_DATA, 8'h00);
    checkOutput("ack_intr", {7'b0, bus.INTR}, 8'h00);
    checkOutput("ack_iflag", {7'b0, bus.I_FLAG}, 8'h00);
    readCause("ack_cause", 8'h02);
    bus.IRQ_IN = 8'h00;
    pulseSet();
    tick(3);
    checkOutput("svc_exit_intr", {7'b0, bus.INTR}, 8'h00);

    $display("[TB] simultaneous sources resolve by priority");
    applyStimulus(8'h20, 8'hFF);
    bus.IRQ_IN = 8'h22;
    tick(3);
    checkOutput("two_pend", bus.IN_DATA, 8'h22);
    tick(1);
    checkOutput("two_intr", {7'b0, bus.INTR}, 8'h01);
    ackCycle();
    checkOutput("first_id", {5'b0, bus.INTR_ID}, 8'h01);
    checkOutput("first_pend", bus.IN_DATA, 8'h20);
    pulseSet();
    tick(1);
    checkOutput("svc_hold_intr", {7'b0, bus.INTR}, 8'h00);
    tick(1);
    checkOutput("second_intr", {7'b0, bus.INTR}, 8'h01);
    ackCycle();
    checkOutput("second_id", {5'b0, bus.INTR_ID}, 8'h05);
    checkOutput("second_pend", bus.IN_DATA, 8'h00);
    bus.IRQ_IN = 8'h00;
    pulseSet();
    tick(3);

    $display("[TB] masking and CLI during request");
    applyStimulus(8'h20, 8'h00);
    bus.IRQ_IN = 8'h08;
    tick(3);
    checkOutput("masked_pend", bus.IN_DATA, 8'h08);
    tick(3);
    checkOutput("masked_intr", {7'b0, bus.INTR}, 8'h00);
    applyStimulus(8'h20, 8'h08);
    tick(1);
    checkOutput("unmask_intr", {7'b0, bus.INTR}, 8'h01);
    bus.I_CLR = 1'b1;
    #1;
    checkOutput("cli_intr_same", {7'b0, bus.INTR}, 8'h00);
    tick(1);
    bus.I_CLR = 1'b0;
    #1;
    checkOutput("cli_intr_next", {7'b0, bus.INTR}, 8'h00);
    checkOutput("cli_pend", bus.IN_DATA, 8'h08);
    checkOutput("cli_iflag", {7'b0, bus.I_FLAG}, 8'h00);
    pulseSet();
    tick(1);
    checkOutput("sei_intr", {7'b0, bus.INTR}, 8'h01);
    ackCycle();
    checkOutput("third_id", {5'b0, bus.INTR_ID}, 8'h03);
    bus.IRQ_IN = 8'h00;
    pulseSet();
    tick(3);

    $display("[TB] ignored ack and edge versus clear race");
    bus.INTR_ACK = 1'b1;
    tick(1);
    bus.INTR_ACK = 1'b0;
    #1;
    checkOutput("idle_ack_id", {5'b0, bus.INTR_ID}, 8'h03);
    checkOutput("idle_ack_pend", bus.IN_DATA, 8'h00);
    checkOutput("idle_ack_intr", {7'b0, bus.INTR}, 8'h00);
    bus.IRQ_IN = 8'h10;
    tick(2);
    applyStimulus(8'h21, 8'h10);
    checkOutput("race_pend", bus.IN_DATA, 8'h10);
    applyStimulus(8'h21, 8'h10);
    checkOutput("clr_pend", bus.IN_DATA, 8'h00);
    tick(3);
    checkOutput("level_once_pend", bus.IN_DATA, 8'h00);

    $display("[TB] reset while requesting");
    applyStimulus(8'h20, 8'hFF);
    bus.IRQ_IN = 8'h11;
    tick(3);
    checkOutput("pre_rst_pend", bus.IN_DATA, 8'h01);
    tick(1);
    checkOutput("pre_rst_intr", {7'b0, bus.INTR}, 8'h01);
    RESET_N = 1'b0;
    tick(1);
    RESET_N = 1'b1;
    #1;
    checkOutput("post_rst_intr", {7'b0, bus.INTR}, 8'h00);
    checkOutput("post_rst_iflag", {7'b0, bus.I_FLAG}, 8'h00);
    checkOutput("post_rst_pend", bus.IN_DATA, 8'h00);
    readCause("post_rst_cause", 8'h00);
    bus.PORT_ID = 8'h24;
    #1;
    checkOutput("unowned_read", bus.IN_DATA, 8'h00);
    bus.PORT_ID = 8'h23;
    applyStimulus(8'h24, 8'hFF);
    pulseSet();
    tick(1);
    checkOutput("rearm_pend", bus.IN_DATA, 8'h11);
    tick(3);
    checkOutput("post_rst_mask_intr", {7'b0, bus.INTR}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
